// File: rtl/lc3b_types.sv
// Shared types for the LC-3b cache slice.
// Holds the width and typedef of the cache performance counters so the
// controller ports and any consumer agree on one definition.
package lc3b_types;

  localparam int LC3B_CNT_WIDTH = 16;

  typedef logic [LC3B_CNT_WIDTH-1:0] lc3b_cnt;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter.
// Ports:
//   clk    in  clock
//   reset  in  synchronous active-high clear (wins over inc)
//   inc    in  add one this cycle unless already at all-ones
//   count  out current count
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    // Hold at all-ones instead of wrapping back to zero.
    if (inc && (count_q != {WIDTH{1'b1}})) begin
      count_d = count_q + {{(WIDTH-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/cache_control.sv
// Sequencing FSM for a direct-mapped, write-back L1 cache (8 sets,
// 128-bit lines). Decides hit/miss from the datapath compare, drives the
// array write enables and datapath mux selects, and runs the physical
// memory handshake for writebacks and line fills.
//
// Handshake: the CPU holds mem_read/mem_write until mem_resp; mem_write
// wins when both are high. Toward physical memory, pmem_read/pmem_write
// stay high until the cycle pmem_resp pulses and drop the cycle after.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   mem_read, mem_write   CPU request
//   hit, dirty            datapath status for the indexed set
//   pmem_resp             physical memory transaction done (pulse)
//   mem_resp              CPU request completes this cycle
//   pmem_read/pmem_write  physical memory fill / writeback strobes
//   pmem_addr_sel         0: CPU address, 1: victim {tag, set}
//   datain_sel            0: CPU write-merged line, 1: pmem line
//   data_write, tag_write, valid_write, dirty_write, dirty_in
//                         array write controls
//   hit_count, miss_count, wb_count  saturating performance counters
//
// The FSM state is visible as state_q for hierarchical probing.
module cache_control
  import lc3b_types::*;
#(
  parameter int CNT_WIDTH = LC3B_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 mem_read,
  input  logic                 mem_write,
  input  logic                 hit,
  input  logic                 dirty,
  input  logic                 pmem_resp,
  output logic                 mem_resp,
  output logic                 pmem_read,
  output logic                 pmem_write,
  output logic                 pmem_addr_sel,
  output logic                 datain_sel,
  output logic                 data_write,
  output logic                 tag_write,
  output logic                 valid_write,
  output logic                 dirty_write,
  output logic                 dirty_in,
  output logic [CNT_WIDTH-1:0] hit_count,
  output logic [CNT_WIDTH-1:0] miss_count,
  output logic [CNT_WIDTH-1:0] wb_count
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    FETCH     = 2'd2
  } cache_state_t;

  cache_state_t state_q;
  cache_state_t state_d;

  logic req;
  logic hit_inc;
  logic miss_inc;
  logic wb_inc;

  assign req = mem_read | mem_write;

  always_comb begin
    state_d       = state_q;
    mem_resp      = 1'b0;
    pmem_read     = 1'b0;
    pmem_write    = 1'b0;
    pmem_addr_sel = 1'b0;
    datain_sel    = 1'b0;
    data_write    = 1'b0;
    tag_write     = 1'b0;
    valid_write   = 1'b0;
    dirty_write   = 1'b0;
    dirty_in      = 1'b0;
    hit_inc       = 1'b0;
    miss_inc      = 1'b0;
    wb_inc        = 1'b0;

    // Reset forces every output low, including the Mealy hit response.
    if (reset) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req) begin
            if (hit) begin
              mem_resp = 1'b1;
              hit_inc  = 1'b1;
              // A write hit merges CPU data into the line and marks it dirty.
              if (mem_write) begin
                data_write  = 1'b1;
                dirty_write = 1'b1;
                dirty_in    = 1'b1;
              end
            end else begin
              miss_inc = 1'b1;
              state_d  = dirty ? WRITEBACK : FETCH;
            end
          end
        end

        WRITEBACK: begin
          pmem_write    = 1'b1;
          pmem_addr_sel = 1'b1;
          if (pmem_resp) begin
            wb_inc  = 1'b1;
            state_d = FETCH;
          end
        end

        FETCH: begin
          pmem_read = 1'b1;
          // The fill lands on the same edge as pmem_resp; the held request
          // is then re-evaluated as a hit from IDLE.
          if (pmem_resp) begin
            datain_sel  = 1'b1;
            data_write  = 1'b1;
            tag_write   = 1'b1;
            valid_write = 1'b1;
            dirty_write = 1'b1;
            dirty_in    = 1'b0;
            state_d     = IDLE;
          end
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  sat_counter #(.WIDTH(CNT_WIDTH)) u_hit_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (hit_inc),
    .count (hit_count)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_miss_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (miss_inc),
    .count (miss_count)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_wb_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (wb_inc),
    .count (wb_count)
  );

endmodule

// File: doc/cache_control.md
# cache_control

Sequencing FSM for the L1 cache built around the 8-set, 128-bit-line data array and its companion tag/valid/dirty arrays. It watches CPU requests, decides hit or miss from the datapath's compare result, and drives array write-enables, datapath mux selects and the physical-memory handshake. The cache is direct-mapped and write-back. The block also keeps saturating hit, miss and writeback counters for performance bring-up.

## Interface
- CNT_WIDTH, 16, width of each performance counter
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high; sampled on rising edge of clk
- mem_read  in  1  CPU read request, held until mem_resp
- mem_write  in  1  CPU write request, held until mem_resp
- hit  in  1  datapath: valid[set] & (tag[set] == addr tag), combinational
- dirty  in  1  datapath: dirty[set] for the indexed set
- pmem_resp  in  1  physical memory transaction complete, one-cycle pulse
- mem_resp  out  1  CPU request complete this cycle
- pmem_read  out  1  line fill request to physical memory
- pmem_write  out  1  line writeback request to physical memory
- pmem_addr_sel  out  1  0: CPU address; 1: {stored tag, set} of victim
- datain_sel  out  1  0: CPU write-merged line; 1: pmem line
- data_write  out  1  write enable to data array
- tag_write  out  1  write enable to tag array
- valid_write  out  1  write enable to valid array (writes 1)
- dirty_write  out  1  write enable to dirty array
- dirty_in  out  1  value written to dirty array
- hit_count, miss_count, wb_count  out  CNT_WIDTH each  performance counters

## Operation
- States: IDLE, WRITEBACK, FETCH. Reset state IDLE.
- A request is `req = mem_read | mem_write`. If both are high, it is treated as a write.
- IDLE, no req: all outputs 0.
- IDLE, req & hit, read: mem_resp = 1. Stay in IDLE. hit_count increments.
- IDLE, req & hit, write:
  - Assert mem_resp, data_write, dirty_write and dirty_in = 1, with datain_sel = 0.
  - Stay in IDLE. hit_count increments.
- IDLE, req & !hit & dirty: go to WRITEBACK. miss_count increments.
- IDLE, req & !hit & !dirty: go to FETCH. miss_count increments.
- WRITEBACK: assert pmem_write with pmem_addr_sel = 1.
  - On pmem_resp: wb_count increments, go to FETCH.
- FETCH: assert pmem_read with pmem_addr_sel = 0.
  - On pmem_resp: for one cycle assert data_write, tag_write, valid_write and dirty_write with dirty_in = 0 and datain_sel = 1, then go to IDLE.
- After a fill, IDLE re-evaluates the held request. It now hits and is counted as a hit as well as a miss, by design.
- pmem strobes are held high continuously until pmem_resp, then drop the following cycle.
- If the CPU request drops mid-miss, the current pmem transaction still completes, the fill is still written, and the FSM returns to IDLE.
- Counters saturate at all-ones with no wrap. All counters are 0 after reset.
- Reset mid-WRITEBACK or mid-FETCH: the next state is IDLE, and pmem_read/pmem_write are 0 from the cycle after reset is sampled. A late pmem_resp arriving in IDLE is ignored.

## Timing
- All outputs are 0 during reset and in IDLE with no request.
- Hit: mem_resp is in the same cycle as the request (Mealy on hit). The array write lands on that clock edge.
- Clean miss:
  - Request at cycle 0.
  - FETCH from cycle 1.
  - pmem_resp at cycle N; fill written at the N edge.
  - IDLE at N+1, with mem_resp at N+1.
- Dirty miss: WRITEBACK from cycle 1 until resp at M, FETCH from M+1 until resp at N, mem_resp at N+1.
- No request is accepted while in WRITEBACK or FETCH.

## Structure
- State enum `cache_state_t` is local to the module.
- Add `lc3b_cnt` (16-bit) typedef to lc3b_types for counter ports.
- One sub-module is natural: `sat_counter` (parameterized width, synchronous reset, inc enable, saturating), instanced three times.
- FSM uses next-state/output always_comb plus an always_ff state register.

## Test plan
- Reset then read with hit=1 -> mem_resp=1 in the same cycle, hit_count=1, no pmem strobe.
- Write with hit=1 -> mem_resp, data_write, dirty_write and dirty_in=1 for one cycle; datain_sel=0.
- Read miss, dirty=0, pmem_resp after 5 cycles -> pmem_read high 5 cycles, then a one-cycle fill with all four write enables and datain_sel=1, then mem_resp once hit=1; miss_count=1, hit_count=1.
- Write miss, dirty=1 -> pmem_write with addr_sel=1 until resp, then pmem_read with addr_sel=0; wb_count=1.
- Reset asserted during FETCH -> IDLE next cycle, pmem_read=0, counters 0; stray pmem_resp ignored.
- Force 65536 hits -> hit_count holds at 0xFFFF.
